// File: rtl/mmio_fifo_bank.sv
// MMIO-mapped FIFO: DATA push/pop, STATUS (flags, count, control) and non-destructive PEEK.
// Read responses are registered and return one cycle after the accepted read strobe.
module mmio_fifo_bank #(
    parameter int                 DATA_W    = 64,
    parameter int                 DEPTH     = 8,
    parameter int                 ADDR_W    = 16,
    parameter int                 TID_W     = 9,
    parameter logic [ADDR_W-1:0]  BASE_ADDR = 16'h0020
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_valid,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [63:0]       wr_data,
    input  logic              rd_valid,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [TID_W-1:0]  rd_tid,
    output logic              resp_valid,
    output logic [TID_W-1:0]  resp_tid,
    output logic [63:0]       resp_data,
    output logic              not_empty
);

    localparam int                PTR_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] STATUS_ADDR = BASE_ADDR + ADDR_W'(2);
    localparam logic [ADDR_W-1:0] PEEK_ADDR   = BASE_ADDR + ADDR_W'(4);
    localparam logic [PTR_W-1:0]  LAST_PTR    = PTR_W'(DEPTH - 1);
    localparam logic [15:0]       DEPTH_W16   = 16'(DEPTH);

    // Non-power-of-two depth: wrap by explicit compare rather than natural overflow.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        if (p == LAST_PTR) begin
            return {PTR_W{1'b0}};
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [15:0]       count_r;
    logic              overflow_r;
    logic              underflow_r;

    logic        push_req_s, pop_req_s, status_rd_s, peek_rd_s, status_wr_s;
    logic        clear_s, flush_s, empty_s, full_s;
    logic        push_ok_s, pop_ok_s, ovf_evt_s, udf_evt_s, hit_s;
    logic [63:0] head_s, status_word_s, resp_data_nxt_s;
    logic [15:0] count_nxt_s;

    // Address decode, push/pop legality and next-state arithmetic from pre-cycle state.
    always_comb begin
        push_req_s  = wr_valid && (wr_addr == BASE_ADDR);
        status_wr_s = wr_valid && (wr_addr == STATUS_ADDR);
        pop_req_s   = rd_valid && (rd_addr == BASE_ADDR);
        status_rd_s = rd_valid && (rd_addr == STATUS_ADDR);
        peek_rd_s   = rd_valid && (rd_addr == PEEK_ADDR);
        hit_s       = pop_req_s || status_rd_s || peek_rd_s;
        clear_s     = status_wr_s && wr_data[0];
        flush_s     = status_wr_s && wr_data[1];
        empty_s     = (count_r == 16'd0);
        full_s      = (count_r == DEPTH_W16);
        // A pop on a full FIFO frees the slot the same-cycle push needs.
        push_ok_s   = push_req_s && (!full_s || pop_req_s);
        pop_ok_s    = pop_req_s && !empty_s;
        ovf_evt_s   = push_req_s && full_s && !pop_req_s;
        udf_evt_s   = pop_req_s && empty_s;

        if (empty_s) begin
            head_s = 64'd0;
        end else begin
            head_s = 64'(mem_r[rd_ptr_r]);
        end

        status_word_s          = 64'd0;
        status_word_s[47:32]   = DEPTH_W16;
        status_word_s[19]      = underflow_r;
        status_word_s[18]      = overflow_r;
        status_word_s[17]      = full_s;
        status_word_s[16]      = empty_s;
        status_word_s[15:0]    = count_r;

        if (pop_req_s || peek_rd_s) begin
            resp_data_nxt_s = head_s;
        end else if (status_rd_s) begin
            resp_data_nxt_s = status_word_s;
        end else begin
            resp_data_nxt_s = resp_data;
        end

        if (flush_s) begin
            count_nxt_s = 16'd0;
        end else begin
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_nxt_s = count_r + 16'd1;
                2'b01:   count_nxt_s = count_r - 16'd1;
                default: count_nxt_s = count_r;
            endcase
        end
    end

    // Entry storage; contents are don't-care outside the live window so no reset.
    always_ff @(posedge clk) begin
        if (push_ok_s && !flush_s) begin
            mem_r[wr_ptr_r] <= wr_data[DATA_W-1:0];
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // Pointers, occupancy, sticky flags (set beats clear) and the registered response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_r    <= {PTR_W{1'b0}};
            wr_ptr_r    <= {PTR_W{1'b0}};
            count_r     <= 16'd0;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
            resp_valid  <= 1'b0;
            resp_tid    <= {TID_W{1'b0}};
            resp_data   <= 64'd0;
        end else begin
            if (flush_s) begin
                rd_ptr_r <= {PTR_W{1'b0}};
                wr_ptr_r <= {PTR_W{1'b0}};
            end else begin
                if (push_ok_s) begin
                    wr_ptr_r <= next_ptr(wr_ptr_r);
                end else begin
                    wr_ptr_r <= wr_ptr_r;
                end
                if (pop_ok_s) begin
                    rd_ptr_r <= next_ptr(rd_ptr_r);
                end else begin
                    rd_ptr_r <= rd_ptr_r;
                end
            end
            count_r     <= count_nxt_s;
            overflow_r  <= ovf_evt_s || (overflow_r && !clear_s);
            underflow_r <= udf_evt_s || (underflow_r && !clear_s);
            resp_valid  <= hit_s;
            if (hit_s) begin
                resp_tid <= rd_tid;
            end else begin
                resp_tid <= resp_tid;
            end
            resp_data   <= resp_data_nxt_s;
        end
    end

    assign not_empty = (count_r != 16'd0);

endmodule
